// File: rtl/orbit_ball.sv
// orbit_ball: one player's ball riding a fixed 60-position circle.
// Keys or auto-spin move an angular index, with hold-to-repeat pacing.
// The index goes through a sine/cosine ROM and a 2-stage pipeline, which
// produces the screen position of the ball centre.
//
// Ports:
//   Clk, Reset   - clock and synchronous active-high reset
//   frame_tick   - one-cycle strobe per video frame; paces index motion
//   keycode[7:0] - current key (KEY_CW / KEY_CCW move, anything else idles)
//   mode[1:0]    - 00 manual, 01 auto CW, 10 auto CCW, 11 frozen
//   Index[5:0]   - current angular index 0..STEPS-1 (increases CCW on screen)
//   BallX/BallY  - ball centre, valid when pos_valid is high
//   BallS        - constant ball size
//   pos_valid    - low for the 2 cycles after an index change
module orbit_ball #(
  parameter int          STEPS         = 60,
  parameter int          RADIUS        = 80,
  parameter int          CENTER_X      = 320,
  parameter int          CENTER_Y      = 240,
  parameter int          START_INDEX   = 0,
  parameter int          STEP_SIZE     = 1,
  parameter int          REPEAT_FRAMES = 4,
  parameter int          BALL_SIZE     = 4,
  parameter logic [7:0]  KEY_CW        = 8'h07,
  parameter logic [7:0]  KEY_CCW       = 8'h04
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [1:0] mode,
  output logic [5:0] Index,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic       pos_valid
);

  localparam int COEF_W = 10;
  localparam int DATA_W = 10;
  localparam int PROD_W = 18;
  localparam int CNT_W  = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  localparam logic signed [PROD_W-1:0] RAD_S   = PROD_W'(RADIUS);
  localparam logic [DATA_W-1:0]        CX      = DATA_W'(CENTER_X);
  localparam logic [DATA_W-1:0]        CY      = DATA_W'(CENTER_Y);
  localparam logic [CNT_W-1:0]         CNT_TOP = CNT_W'(REPEAT_FRAMES - 1);

  // round(256*sin(6k deg)) for the first quadrant, k = 0..15
  function automatic logic signed [COEF_W-1:0] quarter_sin(input logic [3:0] k);
    case (k)
      4'd0:    return 10'sd0;
      4'd1:    return 10'sd27;
      4'd2:    return 10'sd53;
      4'd3:    return 10'sd79;
      4'd4:    return 10'sd104;
      4'd5:    return 10'sd128;
      4'd6:    return 10'sd150;
      4'd7:    return 10'sd171;
      4'd8:    return 10'sd190;
      4'd9:    return 10'sd207;
      4'd10:   return 10'sd222;
      4'd11:   return 10'sd234;
      4'd12:   return 10'sd243;
      4'd13:   return 10'sd250;
      4'd14:   return 10'sd255;
      default: return 10'sd256;
    endcase
  endfunction

  // Full circle folded onto the quadrant table by symmetry.
  function automatic logic signed [COEF_W-1:0] sin_lut(input logic [5:0] k);
    if (k <= 6'd15)      return quarter_sin(k[3:0]);
    else if (k <= 6'd30) return quarter_sin(4'(6'd30 - k));
    else if (k <= 6'd45) return -quarter_sin(4'(k - 6'd30));
    else                 return -quarter_sin(4'(6'd60 - k));
  endfunction

  // cos(6k) = sin(6(k+15))
  function automatic logic signed [COEF_W-1:0] cos_lut(input logic [5:0] k);
    return sin_lut((k >= 6'd45) ? (k - 6'd45) : (k + 6'd15));
  endfunction

  // (RADIUS * coef) >>> 8 : floor of the scaled offset
  function automatic logic signed [DATA_W-1:0] scale_floor(input logic signed [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] c_ext;
    logic signed [PROD_W-1:0] prod;
    c_ext = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
    prod  = RAD_S * c_ext;
    return DATA_W'(prod >>> 8);
  endfunction

  logic [5:0]        index_q, index_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        held_q, held_d;
  logic [1:0]        mode_q, mode_d;
  logic              move_cw, move_ccw, key_hit, cnt_last, idx_chg;
  logic [6:0]        sum_ccw;
  logic [5:0]        idx_ccw, idx_cw;

  logic signed [COEF_W-1:0] cos_p1_q, cos_p1_d, sin_p1_q, sin_p1_d;
  logic                     vld_p1_q, vld_p1_d;
  logic signed [DATA_W-1:0] offx_p2, offy_p2;
  logic [DATA_W-1:0]        ball_x_p2_q, ball_x_p2_d, ball_y_p2_q, ball_y_p2_d;
  logic                     vld_p2_q, vld_p2_d;

  always_comb begin
    sum_ccw = {1'b0, index_q} + 7'(STEP_SIZE);
    idx_ccw = (sum_ccw >= 7'(STEPS)) ? 6'(sum_ccw - 7'(STEPS)) : sum_ccw[5:0];
    idx_cw  = (index_q < 6'(STEP_SIZE))
              ? 6'({1'b0, index_q} + 7'(STEPS) - 7'(STEP_SIZE))
              : (index_q - 6'(STEP_SIZE));
  end

  // Index control: moves only on frame ticks; a mode change resets pacing.
  always_comb begin
    index_d  = index_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    mode_d   = mode;
    move_cw  = 1'b0;
    move_ccw = 1'b0;
    key_hit  = (keycode == KEY_CW) || (keycode == KEY_CCW);
    cnt_last = (cnt_q == CNT_TOP);
    if (mode != mode_q) begin
      cnt_d  = '0;
      held_d = '0;
    end else if (frame_tick) begin
      case (mode)
        2'b00: begin
          if (key_hit && (keycode != held_q)) begin
            move_ccw = (keycode == KEY_CCW);
            move_cw  = (keycode == KEY_CW);
            cnt_d    = '0;
            held_d   = keycode;
          end else if (key_hit) begin
            if (cnt_last) begin
              move_ccw = (keycode == KEY_CCW);
              move_cw  = (keycode == KEY_CW);
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d  = '0;
            held_d = '0;
          end
        end
        2'b01, 2'b10: begin
          if (cnt_last) begin
            move_cw  = (mode == 2'b01);
            move_ccw = (mode == 2'b10);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (move_ccw)     index_d = idx_ccw;
    else if (move_cw) index_d = idx_cw;
    idx_chg = (index_d != index_q);
  end

  // ---- stage p1: ROM lookup of the current index ----
  always_comb begin
    cos_p1_d = cos_lut(index_q);
    sin_p1_d = sin_lut(index_q);
    // p1 data describes the index held after this edge only if it doesn't move
    vld_p1_d = ~idx_chg;
  end

  // ---- stage p2: scale by radius and offset from centre (screen y grows down) ----
  always_comb begin
    offx_p2     = scale_floor(cos_p1_q);
    offy_p2     = scale_floor(sin_p1_q);
    ball_x_p2_d = CX + $unsigned(offx_p2);
    ball_y_p2_d = CY - $unsigned(offy_p2);
    vld_p2_d    = vld_p1_q & ~idx_chg;
  end

  always_ff @(posedge Clk) begin
    cos_p1_q <= cos_p1_d;
    sin_p1_q <= sin_p1_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      index_q     <= 6'(START_INDEX);
      cnt_q       <= '0;
      held_q      <= '0;
      mode_q      <= mode_d;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      ball_x_p2_q <= CX;
      ball_y_p2_q <= CY;
    end else begin
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      mode_q      <= mode_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      ball_x_p2_q <= ball_x_p2_d;
      ball_y_p2_q <= ball_y_p2_d;
    end
  end

  assign Index     = index_q;
  assign BallX     = ball_x_p2_q;
  assign BallY     = ball_y_p2_q;
  assign BallS     = 10'(BALL_SIZE);
  assign pos_valid = vld_p2_q;

endmodule
